demux_stream: RTL and testbench

Registered 1:2 stream demultiplexer: the distribution counterpart of the 2:1 `mux`. A single valid/ready input stream is routed word by word to one of two output channels (A or B), chosen by a per-word selector. Each channel has its own one-word holding slot, so a stalled sink on one side never corrupts the other. It sits wherever the MIPS datapath or debug unit must fan one producer out to two consumers, for example a shared read-data bus returning to either the instruction or the data path.

---
 rtl/demux_stream_pkg.sv | 12 +
 rtl/demux_stream_slot.sv | 70 +++++++
 rtl/demux_stream.sv | 80 ++++++++
 tb/tb_demux_stream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared encodings for the 1:2 stream demultiplexer: selector values and slot states.
package demux_stream_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_stream_slot.sv
// One-word holding slot for a demux output channel: EMPTY/FULL FSM, data register
// and a wrapping count of delivered words.
module demux_stream_slot
    import demux_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 11,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   sink_ready,
    output logic                   valid,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   can_load
);

    slot_state_t            state_r;
    logic [DATA_WIDTH-1:0]  data_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   drain_s;

    assign drain_s  = (state_r == FULL) && sink_ready;
    assign can_load = (state_r == EMPTY) || drain_s;

    assign valid    = (state_r == FULL);
    assign data_out = data_r;
    assign count    = count_r;

    // Slot FSM, data register and delivered-word counter; a load while draining keeps the slot FULL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
            data_r  <= {DATA_WIDTH{1'b0}};
            count_r <= {COUNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (load) begin
                        state_r <= FULL;
                        data_r  <= data_in;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    if (load) begin
                        state_r <= FULL;
                        data_r  <= data_in;
                    end else if (sink_ready) begin
                        state_r <= EMPTY;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
            if (drain_s) begin
                count_r <= count_r + COUNT_WIDTH'(1'b1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/demux_stream.sv
// Registered 1:2 stream demultiplexer: routes each accepted word to channel A or B
// according to i_selector; each channel owns an independent one-word slot.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int INPUT_OUTPUT_LENGTH = 11,
    parameter int COUNTER_LENGTH      = 16
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [INPUT_OUTPUT_LENGTH-1:0] i_data,
    input  logic                           i_selector,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [INPUT_OUTPUT_LENGTH-1:0] o_data_A,
    output logic                           o_valid_A,
    input  logic                           i_ready_A,
    output logic [INPUT_OUTPUT_LENGTH-1:0] o_data_B,
    output logic                           o_valid_B,
    input  logic                           i_ready_B,
    output logic [COUNTER_LENGTH-1:0]      o_count_A,
    output logic [COUNTER_LENGTH-1:0]      o_count_B
);

    logic sel_a_s;
    logic can_load_a_s;
    logic can_load_b_s;
    logic ready_s;
    logic load_a_s;
    logic load_b_s;

    assign sel_a_s = (i_selector == SEL_A);

    // Input ready follows the slot addressed by the current selector, held low during reset.
    always_comb begin
        ready_s = 1'b0;
        if (i_reset) begin
            ready_s = 1'b0;
        end else if (sel_a_s) begin
            ready_s = can_load_a_s;
        end else begin
            ready_s = can_load_b_s;
        end
    end

    assign o_ready  = ready_s;
    assign load_a_s = i_valid && ready_s && sel_a_s;
    assign load_b_s = i_valid && ready_s && !sel_a_s;

    demux_stream_slot #(
        .DATA_WIDTH  (INPUT_OUTPUT_LENGTH),
        .COUNT_WIDTH (COUNTER_LENGTH)
    ) u_slot_a (
        .clk        (i_clock),
        .reset      (i_reset),
        .load       (load_a_s),
        .data_in    (i_data),
        .sink_ready (i_ready_A),
        .valid      (o_valid_A),
        .data_out   (o_data_A),
        .count      (o_count_A),
        .can_load   (can_load_a_s)
    );

    demux_stream_slot #(
        .DATA_WIDTH  (INPUT_OUTPUT_LENGTH),
        .COUNT_WIDTH (COUNTER_LENGTH)
    ) u_slot_b (
        .clk        (i_clock),
        .reset      (i_reset),
        .load       (load_b_s),
        .data_in    (i_data),
        .sink_ready (i_ready_B),
        .valid      (o_valid_B),
        .data_out   (o_data_B),
        .count      (o_count_B),
        .can_load   (can_load_b_s)
    );

endmodule

// File: tb/tb_demux_stream.sv
// Directed self-checking bench for demux_stream; a second instance with a 4-bit
// counter covers counter wrap-around.
module tb_demux_stream;

    logic        clk;
    logic        reset;
    logic [10:0] data;
    logic        sel;
    logic        valid;
    logic        ready_a;
    logic        ready_b;
    logic        o_ready;
    logic [10:0] data_a;
    logic [10:0] data_b;
    logic        valid_a;
    logic        valid_b;
    logic [15:0] count_a;
    logic [15:0] count_b;

    logic        w_reset;
    logic [10:0] w_data;
    logic        w_valid;
    logic        w_o_ready;
    logic [10:0] w_data_a;
    logic [10:0] w_data_b;
    logic        w_valid_a;
    logic        w_valid_b;
    logic [3:0]  w_count_a;
    logic [3:0]  w_count_b;

    int n_checks = 0;
    int n_fail   = 0;

    demux_stream dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_data     (data),
        .i_selector (sel),
        .i_valid    (valid),
        .o_ready    (o_ready),
        .o_data_A   (data_a),
        .o_valid_A  (valid_a),
        .i_ready_A  (ready_a),
        .o_data_B   (data_b),
        .o_valid_B  (valid_b),
        .i_ready_B  (ready_b),
        .o_count_A  (count_a),
        .o_count_B  (count_b)
    );

    demux_stream #(.INPUT_OUTPUT_LENGTH(11), .COUNTER_LENGTH(4)) dut_w (
        .i_clock    (clk),
        .i_reset    (w_reset),
        .i_data     (w_data),
        .i_selector (1'b0),
        .i_valid    (w_valid),
        .o_ready    (w_o_ready),
        .o_data_A   (w_data_a),
        .o_valid_A  (w_valid_a),
        .i_ready_A  (1'b1),
        .o_data_B   (w_data_b),
        .o_valid_B  (w_valid_b),
        .i_ready_B  (1'b1),
        .o_count_A  (w_count_a),
        .o_count_B  (w_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        valid   = 1'b1;
        data    = 11'h7FF;
        sel     = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;
        w_reset = 1'b1;
        w_valid = 1'b0;
        w_data  = 11'h000;

        // Reset held for 3 cycles with valid asserted
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_o_ready", 32'(o_ready), 32'd0);
        end
        chk("rst_valid_a", 32'(valid_a), 32'd0);
        chk("rst_valid_b", 32'(valid_b), 32'd0);
        chk("rst_data_a", 32'(data_a), 32'd0);
        chk("rst_data_b", 32'(data_b), 32'd0);
        chk("rst_count_a", 32'(count_a), 32'd0);
        chk("rst_count_b", 32'(count_b), 32'd0);
        reset   = 1'b0;
        w_reset = 1'b0;
        valid   = 1'b0;
        tick();
        chk("rst_nothing_accepted", 32'(valid_a), 32'd0);

        // Single word to A
        data  = 11'h2A5;
        sel   = 1'b0;
        valid = 1'b1;
        #1;
        chk("a1_o_ready", 32'(o_ready), 32'd1);
        tick();
        valid = 1'b0;
        chk("a1_valid_a", 32'(valid_a), 32'd1);
        chk("a1_data_a", 32'(data_a), 32'h2A5);
        chk("a1_count_a_pre", 32'(count_a), 32'd0);
        chk("a1_valid_b", 32'(valid_b), 32'd0);
        tick();
        chk("a1_valid_a_drop", 32'(valid_a), 32'd0);
        chk("a1_count_a", 32'(count_a), 32'd1);
        chk("a1_count_b", 32'(count_b), 32'd0);
        chk("a1_valid_b_idle", 32'(valid_b), 32'd0);

        // Backpressure on B
        ready_b = 1'b0;
        data    = 11'h001;
        sel     = 1'b1;
        valid   = 1'b1;
        #1;
        chk("bp_first_ready", 32'(o_ready), 32'd1);
        tick();
        data = 11'h003;
        #1;
        chk("bp_second_b_blocked", 32'(o_ready), 32'd0);
        tick();
        chk("bp_valid_b_held", 32'(valid_b), 32'd1);
        chk("bp_data_b_held", 32'(data_b), 32'h001);
        data = 11'h002;
        sel  = 1'b0;
        #1;
        chk("bp_a_ready", 32'(o_ready), 32'd1);
        tick();
        chk("bp_valid_a", 32'(valid_a), 32'd1);
        chk("bp_data_a", 32'(data_a), 32'h002);
        chk("bp_data_b_stable", 32'(data_b), 32'h001);
        data = 11'h003;
        sel  = 1'b1;
        #1;
        chk("bp_b_still_blocked", 32'(o_ready), 32'd0);
        tick();
        chk("bp_a_drained", 32'(valid_a), 32'd0);
        chk("bp_count_a", 32'(count_a), 32'd2);
        chk("bp_data_b_stable2", 32'(data_b), 32'h001);
        ready_b = 1'b1;
        #1;
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        tick();
        valid = 1'b0;
        chk("bp_reload_valid_b", 32'(valid_b), 32'd1);
        chk("bp_reload_data_b", 32'(data_b), 32'h003);
        chk("bp_count_b1", 32'(count_b), 32'd1);
        tick();
        chk("bp_valid_b_drop", 32'(valid_b), 32'd0);
        chk("bp_count_b2", 32'(count_b), 32'd2);

        // Clear counts before streaming
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("pre_stream_count_a", 32'(count_a), 32'd0);

        // Streaming: 8 alternating words, both sinks ready
        for (int i = 0; i < 8; i++) begin
            data  = 11'(11'h100 + 11'(i));
            sel   = (i % 2) == 1;
            valid = 1'b1;
            #1;
            chk("st_o_ready", 32'(o_ready), 32'd1);
            tick();
            if ((i % 2) == 0) begin
                chk("st_valid_a", 32'(valid_a), 32'd1);
                chk("st_data_a", 32'(data_a), 32'h100 + 32'(i));
            end else begin
                chk("st_valid_b", 32'(valid_b), 32'd1);
                chk("st_data_b", 32'(data_b), 32'h100 + 32'(i));
            end
        end
        valid = 1'b0;
        tick();
        chk("st_count_a", 32'(count_a), 32'd4);
        chk("st_count_b", 32'(count_b), 32'd4);
        chk("st_idle_a", 32'(valid_a), 32'd0);
        chk("st_idle_b", 32'(valid_b), 32'd0);

        // Reset mid-transfer with both slots FULL and stalled
        ready_a = 1'b0;
        ready_b = 1'b0;
        data    = 11'h055;
        sel     = 1'b0;
        valid   = 1'b1;
        tick();
        data = 11'h066;
        sel  = 1'b1;
        tick();
        valid = 1'b0;
        chk("mr_full_a", 32'(valid_a), 32'd1);
        chk("mr_full_b", 32'(valid_b), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_o_ready", 32'(o_ready), 32'd0);
        tick();
        reset = 1'b0;
        chk("mr_valid_a", 32'(valid_a), 32'd0);
        chk("mr_valid_b", 32'(valid_b), 32'd0);
        chk("mr_count_a", 32'(count_a), 32'd0);
        chk("mr_count_b", 32'(count_b), 32'd0);
        chk("mr_data_a", 32'(data_a), 32'd0);
        ready_a = 1'b1;
        ready_b = 1'b1;
        tick();
        tick();
        chk("mr_stale_a", 32'(valid_a), 32'd0);
        chk("mr_stale_b", 32'(valid_b), 32'd0);
        chk("mr_after_count_a", 32'(count_a), 32'd0);
        chk("mr_after_count_b", 32'(count_b), 32'd0);

        // Counter wrap on the 4-bit instance: 17 words to A
        w_valid = 1'b1;
        w_data  = 11'h011;
        tick();
        for (int k = 1; k <= 17; k++) begin
            w_data = 11'(11'h011 + 11'(k));
            if (k == 17) begin
                w_valid = 1'b0;
            end else begin
                w_valid = 1'b1;
            end
            tick();
            chk("wrap_count_a", 32'(w_count_a), 32'(k % 16));
        end
        chk("wrap_idle", 32'(w_valid_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
